// File: rtl/ipf_pkg.sv
// ipf_pkg: shared widths and FSM state type
// for the IPF feed sequencer slice.
package ipf_pkg;

  localparam int IN_W   = 8;
  localparam int W_W    = 4;
  localparam int RES_W  = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LOAD_I,
    LOAD_W,
    COMP,
    DRAIN,
    DONE
  } ipf_state_e;

endpackage

// File: rtl/ipf_feed_ctrl_if.sv
// ipf_feed_ctrl_if: sequencer <-> IPF engine
// feed and result signals.
interface ipf_feed_ctrl_if;
  import ipf_pkg::*;

  logic             ready;
  logic             endinput;
  logic [IN_W-1:0]  i_data;
  logic [W_W-1:0]   w_data;
  logic             res_valid;
  logic [RES_W-1:0] res;
  logic             finish;

  modport master (
    output ready, endinput, i_data, w_data,
    input  res_valid, res, finish
  );

  modport slave (
    input  ready, endinput, i_data, w_data,
    output res_valid, res, finish
  );

endinterface

// File: rtl/ipf_res_capture.sv
// ipf_res_capture: registers IPF results into
// the result buffer, counts them, flags overflow.
module ipf_res_capture
  import ipf_pkg::*;
#(
  parameter int MAX_RES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res,
  input  logic [ADDR_W-1:0] r_base,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_waddr,
  output logic [RES_W-1:0]  res_wdata,
  output logic [7:0]        res_cnt,
  output logic              err_ovf
);

  localparam logic [7:0] CAP = 8'(MAX_RES);

  // one-cycle write pipeline; full buffer drops the word
  always_ff @(posedge clk) begin
    if (rst) begin
      res_we    <= 1'b0;
      res_waddr <= '0;
      res_wdata <= '0;
      res_cnt   <= '0;
      err_ovf   <= 1'b0;
    end else begin
      res_we <= 1'b0;
      if (clr) begin
        res_cnt <= '0;
        err_ovf <= 1'b0;
      end else if (en && res_valid) begin
        if (res_cnt == CAP) begin
          err_ovf <= 1'b1;
        end else begin
          res_we    <= 1'b1;
          res_wdata <= res;
          res_waddr <= r_base + ADDR_W'(res_cnt);
          res_cnt   <= res_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ipf_feed_ctrl.sv
// ipf_feed_ctrl: schedules input/weight loads and
// compute passes into IPF, then drains its results.
module ipf_feed_ctrl
  import ipf_pkg::*;
#(
  parameter int I_PER_GRP = 3,
  parameter int W_PER_GRP = 2,
  parameter int COMP_CYC  = 3,
  parameter int N_GRP     = 2,
  parameter int MAX_RES   = 12,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] r_base,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              err_tmo,
  output logic              i_rd,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [IN_W-1:0]   i_rdata,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [W_W-1:0]    w_rdata,
  ipf_feed_ctrl_if.master   ipf,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_waddr,
  output logic [RES_W-1:0]  res_wdata,
  output logic [7:0]        res_cnt
);

  localparam logic [7:0]  LAST_I = 8'(I_PER_GRP - 1);
  localparam logic [7:0]  LAST_C = 8'(COMP_CYC - 1);
  localparam logic [7:0]  LAST_P = 8'(W_PER_GRP - 1);
  localparam logic [7:0]  LAST_G = 8'(N_GRP - 1);
  localparam logic [15:0] LAST_T = 16'(TIMEOUT - 1);

  ipf_state_e state_q, state_d;

  logic [ADDR_W-1:0] ib_q, wb_q, rb_q;
  logic [7:0]  ic_q, cc_q, pc_q, gc_q, k_q;
  logic [7:0]  w_off;
  logic [15:0] tmo_q;
  logic fin_q, rdy_q, end_q, tmo_err_q;
  logic last_i, last_c, last_p, last_g;
  logic job_end, tmo_hit, accept, fin_clr;

  assign last_i  = (ic_q == LAST_I);
  assign last_c  = (cc_q == LAST_C);
  assign last_p  = (pc_q == LAST_P);
  assign last_g  = (gc_q == LAST_G);
  assign job_end = (state_q == COMP) && last_c
                && last_p && last_g;
  assign tmo_hit = (state_q == DRAIN) && !fin_q
                && (tmo_q == LAST_T);
  assign accept  = (state_q == IDLE) && start;
  assign fin_clr = (state_q != IDLE) && ipf.finish;

  assign w_off = (state_q == COMP) ? pc_q + 8'd1
                                   : 8'd0;

  assign i_addr = i_rd ? ib_q + ADDR_W'(k_q) : '0;
  assign w_addr = w_rd ? wb_q + ADDR_W'(w_off) : '0;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err_tmo = tmo_err_q;

  assign ipf.ready    = rdy_q;
  assign ipf.endinput = end_q | (job_end & rdy_q);
  assign ipf.i_data   = (state_q == LOAD_I) ? i_rdata
                                            : '0;
  assign ipf.w_data   = (state_q == LOAD_W) ? w_rdata
                                            : '0;

  // next state plus the read strobes that lead each load
  always_comb begin
    state_d = state_q;
    i_rd    = 1'b0;
    w_rd    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        i_rd    = 1'b1;
        state_d = LOAD_I;
      end
      LOAD_I: begin
        if (last_i) begin
          w_rd    = 1'b1;
          state_d = LOAD_W;
        end else begin
          i_rd = 1'b1;
        end
      end
      LOAD_W: state_d = COMP;
      COMP: begin
        if (last_c) begin
          if (!last_p) begin
            w_rd    = 1'b1;
            state_d = LOAD_W;
          end else if (!last_g) begin
            i_rd    = 1'b1;
            state_d = LOAD_I;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fin_q || tmo_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, pass/group counters, IPF handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ib_q      <= '0;
      wb_q      <= '0;
      rb_q      <= '0;
      ic_q      <= '0;
      cc_q      <= '0;
      pc_q      <= '0;
      gc_q      <= '0;
      k_q       <= '0;
      tmo_q     <= '0;
      fin_q     <= 1'b0;
      rdy_q     <= 1'b0;
      end_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ib_q      <= i_base;
        wb_q      <= w_base;
        rb_q      <= r_base;
        ic_q      <= '0;
        cc_q      <= '0;
        pc_q      <= '0;
        gc_q      <= '0;
        k_q       <= '0;
        tmo_q     <= '0;
        fin_q     <= 1'b0;
        rdy_q     <= 1'b1;
        end_q     <= 1'b0;
        tmo_err_q <= 1'b0;
      end else begin
        if (i_rd) k_q <= k_q + 8'd1;
        if (state_q == LOAD_I)
          ic_q <= last_i ? 8'd0 : ic_q + 8'd1;
        if (state_q == COMP) begin
          cc_q <= last_c ? 8'd0 : cc_q + 8'd1;
          if (last_c) begin
            pc_q <= last_p ? 8'd0 : pc_q + 8'd1;
            if (last_p) gc_q <= gc_q + 8'd1;
          end
        end
        if (state_q == DRAIN) tmo_q <= tmo_q + 16'd1;
        if (fin_clr) fin_q <= 1'b1;
        if (fin_clr || tmo_hit) begin
          rdy_q <= 1'b0;
          end_q <= 1'b0;
        end else if (job_end) begin
          end_q <= 1'b1;
        end
        if (tmo_hit) tmo_err_q <= 1'b1;
      end
    end
  end

  ipf_res_capture #(
    .MAX_RES (MAX_RES)
  ) u_cap (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (state_q != IDLE),
    .res_valid (ipf.res_valid),
    .res       (ipf.res),
    .r_base    (rb_q),
    .res_we    (res_we),
    .res_waddr (res_waddr),
    .res_wdata (res_wdata),
    .res_cnt   (res_cnt),
    .err_ovf   (err_ovf)
  );

endmodule

// File: tb/tb_ipf_feed_ctrl.sv
// tb_ipf_feed_ctrl: table-driven feed schedule plus
// directed sequences for drain, overflow, timeout, reset.
module tb_ipf_feed_ctrl;
  import ipf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] i_base = '0, w_base = '0, r_base = '0;
  logic        busy, done, err_ovf, err_tmo;
  logic        i_rd, w_rd, res_we;
  logic [15:0] i_addr, w_addr, res_waddr;
  logic [7:0]  i_rdata = '0;
  logic [3:0]  w_rdata = '0;
  logic [31:0] res_wdata;
  logic [7:0]  res_cnt;

  ipf_feed_ctrl_if ifc ();

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  logic [31:0] rbuf [256];

  always #5 clk = ~clk;

  ipf_feed_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .i_base    (i_base),
    .w_base    (w_base),
    .r_base    (r_base),
    .busy      (busy),
    .done      (done),
    .err_ovf   (err_ovf),
    .err_tmo   (err_tmo),
    .i_rd      (i_rd),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .ipf       (ifc),
    .res_we    (res_we),
    .res_waddr (res_waddr),
    .res_wdata (res_wdata),
    .res_cnt   (res_cnt)
  );

  // buffer models: input = A0+addr, weight = 3+addr
  always @(posedge clk) begin
    if (i_rd) i_rdata <= 8'hA0 + i_addr[7:0];
    if (w_rd) w_rdata <= 4'h3 + w_addr[3:0];
    if (res_we) begin
      rbuf[res_waddr[7:0]] <= res_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  typedef struct {
    logic       ird;
    logic [7:0] ioff;
    logic       wrd;
    logic [7:0] woff;
    logic       idv;
    logic [7:0] idoff;
    logic       wdv;
    logic [3:0] wdoff;
    logic       endi;
  } vec_t;

  vec_t vec [23];

  function automatic vec_t mk(
    input logic ird, input logic [7:0] ioff,
    input logic wrd, input logic [7:0] woff,
    input logic idv, input logic [7:0] idoff,
    input logic wdv, input logic [3:0] wdoff,
    input logic endi);
    vec_t v;
    v.ird = ird;   v.ioff = ioff;
    v.wrd = wrd;   v.woff = woff;
    v.idv = idv;   v.idoff = idoff;
    v.wdv = wdv;   v.wdoff = wdoff;
    v.endi = endi;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 128'({busy, done, err_ovf, err_tmo,
                  i_rd, i_addr, w_rd, w_addr,
                  ifc.ready, ifc.endinput,
                  ifc.i_data, ifc.w_data,
                  res_we, res_waddr, res_wdata,
                  res_cnt}), 128'(0));
  endtask

  task automatic run_feed(
    input logic [15:0] ib, input logic [15:0] wb,
    input logic [15:0] rb, input int sf,
    input int sn, input int bs, input int fa,
    input int abort);
    logic [15:0] ei, ew;
    logic [7:0]  edat;
    logic [3:0]  ewd;
    @(negedge clk);
    i_base = ib; w_base = wb; r_base = rb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("job_start", 128'({busy, err_ovf, err_tmo,
                          res_cnt}),
        128'({1'b1, 1'b0, 1'b0, 8'd0}));
    for (int c = 0; c < 23; c++) begin
      ei   = vec[c].ird ? ib + 16'(vec[c].ioff) : 16'h0;
      ew   = vec[c].wrd ? wb + 16'(vec[c].woff) : 16'h0;
      edat = vec[c].idv ? 8'hA0 + ib[7:0]
                          + vec[c].idoff : 8'h0;
      ewd  = vec[c].wdv ? 4'h3 + wb[3:0]
                          + vec[c].wdoff : 4'h0;
      chk($sformatf("feed[%0d]", c),
          128'({i_rd, i_addr, w_rd, w_addr,
                ifc.i_data, ifc.w_data,
                ifc.endinput}),
          128'({vec[c].ird, ei, vec[c].wrd, ew,
                edat, ewd, vec[c].endi}));
      if (c == abort) begin
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst");
        rst = 1'b0;
        return;
      end
      ifc.res_valid = (c >= sf) && (c < sf + sn);
      ifc.res = 32'h100 + 32'(c - sf);
      start  = (c == bs);
      i_base = (c == bs) ? 16'hFFFF : ib;
      w_base = (c == bs) ? 16'hFFFF : wb;
      r_base = (c == bs) ? 16'hFFFF : rb;
      ifc.finish = (c == fa);
      @(negedge clk);
    end
    ifc.res_valid = 1'b0;
    ifc.finish = 1'b0;
    start = 1'b0;
    i_base = ib; w_base = wb; r_base = rb;
  endtask

  task automatic wait_done(input int max,
                           output int n);
    n = 0;
    while (n < max && !done) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, we0;
    ifc.res_valid = 1'b0;
    ifc.res = '0;
    ifc.finish = 1'b0;

    for (int c = 0; c < 23; c++)
      vec[c] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[1]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
    vec[2]  = mk(1, 2, 0, 0, 1, 1, 0, 0, 0);
    vec[3]  = mk(0, 0, 1, 0, 1, 2, 0, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec[7]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    vec[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
    vec[11] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0);
    vec[12] = mk(1, 4, 0, 0, 1, 3, 0, 0, 0);
    vec[13] = mk(1, 5, 0, 0, 1, 4, 0, 0, 0);
    vec[14] = mk(0, 0, 1, 0, 1, 5, 0, 0, 0);
    vec[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec[18] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    vec[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
    vec[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    we0 = we_cnt;
    run_feed(16'h0, 16'h0, 16'h20, 5, 12, -1, -1, -1);
    chk("drain_hold", 128'({ifc.ready, ifc.endinput,
                           busy, done}),
        128'(4'b1110));
    ifc.finish = 1'b1;
    @(negedge clk);
    ifc.finish = 1'b0;
    chk("fin_drop", 128'({ifc.ready, ifc.endinput,
                         busy, done}),
        128'(4'b0010));
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'(1));
    chk("cnt12", 128'(res_cnt), 128'(12));
    chk("err_clean", 128'({err_ovf, err_tmo}),
        128'(0));
    chk("we12", 128'(we_cnt - we0), 128'(12));
    for (int i = 0; i < 12; i++)
      chk($sformatf("rbuf[%0d]", i),
          128'(rbuf[8'h20 + 8'(i)]),
          128'(32'h100 + 32'(i)));
    @(negedge clk);
    chk("idle_after", 128'({busy, done}), 128'(0));

    we0 = we_cnt;
    run_feed(16'h0, 16'h0, 16'h40, 3, 13, -1, 22, -1);
    chk("early_fin", 128'({ifc.ready, ifc.endinput,
                          busy, done}),
        128'(4'b0010));
    @(negedge clk);
    chk("ovf_done", 128'(done), 128'(1));
    chk("ovf_flag", 128'({err_ovf, err_tmo}),
        128'(2'b10));
    chk("ovf_cnt", 128'(res_cnt), 128'(12));
    chk("ovf_we", 128'(we_cnt - we0), 128'(12));

    run_feed(16'h0, 16'h0, 16'h60, 0, 0, -1, -1, -1);
    wait_done(1200, n);
    chk("tmo_done", 128'(done), 128'(1));
    chk("tmo_len", 128'(n), 128'(1024));
    chk("tmo_flags", 128'({err_tmo, ifc.ready,
                          ifc.endinput}),
        128'(3'b100));

    run_feed(16'h0, 16'h0, 16'h70, 0, 0, -1, -1, 10);

    we0 = we_cnt;
    run_feed(16'h10, 16'h08, 16'h80, 8, 4, 5, -1, -1);
    ifc.finish = 1'b1;
    ifc.res_valid = 1'b1;
    ifc.res = 32'h5A5A;
    @(negedge clk);
    ifc.finish = 1'b0;
    ifc.res_valid = 1'b0;
    chk("last_wr", 128'({res_we, res_waddr, res_wdata,
                        done}),
        128'({1'b1, 16'h84, 32'h5A5A, 1'b0}));
    @(negedge clk);
    chk("last_done", 128'(done), 128'(1));
    chk("last_cnt", 128'({res_cnt, err_ovf, err_tmo}),
        128'({8'd5, 2'b00}));
    chk("last_we", 128'(we_cnt - we0), 128'(5));
    chk("last_rbuf", 128'(rbuf[8'h84]),
        128'(32'h5A5A));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rbuf8[%0d]", i),
          128'(rbuf[8'h80 + 8'(i)]),
          128'(32'h100 + 32'(i)));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
